// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// The stages act as master (raise requests) and the controller is the slave.
interface pipe_ctrl_if #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 6
);
  logic [STAGES-1:0] stallreq;
  logic              mc_start;
  logic [CNT_W-1:0]  mc_len;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic [STAGES:0]   stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic [STAGES-1:0] stage_valid;
  logic              mc_busy;
  logic              mc_done;

  modport master (
    output stallreq, mc_start, mc_len, flush_req, flush_pc,
    input  stall, flush, new_pc, stage_valid, mc_busy, mc_done
  );

  modport slave (
    input  stallreq, mc_start, mc_len, flush_req, flush_pc,
    output stall, flush, new_pc, stage_valid, mc_busy, mc_done
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall bus generation, multi-cycle EX timer,
// exception/eret flush with PC redirect and per-stage valid tracking.
module pipe_ctrl #(
  parameter int unsigned STAGES    = 5,
  parameter int unsigned EX_STAGE  = 2,
  parameter int unsigned EXC_STAGE = 3,
  parameter int unsigned CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              done_q;
  logic              done_nxt;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_nxt;
  logic [STAGES-1:0] valid_prev;
  logic [STAGES-1:0] req;
  logic [STAGES:0]   stall;
  logic              busy;
  logic              start_ok;
  logic              hold;
  logic              flush;

  assign busy     = (cnt != '0);
  assign flush    = bus.flush_req & ~rst;
  assign start_ok = bus.mc_start & ~busy & (bus.mc_len != '0);
  assign hold     = busy | start_ok;
  assign req      = bus.stallreq | (STAGES'(hold) << EX_STAGE);

  // Stage k stalling freezes itself and everything upstream, down to the PC.
  always_comb begin : stall_gen
    logic acc;
    acc   = 1'b0;
    stall = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc          = acc | req[i];
      stall[i + 1] = acc;
    end
    stall[0] = acc;
    if (rst || flush) begin
      stall = '0;
    end
  end

  // Stage -1 (instruction fetch source) always supplies a real instruction.
  assign valid_prev = {valid_q[STAGES-2:0], 1'b1};

  always_comb begin : next_gen
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    valid_nxt = valid_q;

    if (start_ok) begin
      cnt_nxt = bus.mc_len - CNT_W'(1);
    end else if (busy) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
    done_nxt = (start_ok && (bus.mc_len == CNT_W'(1))) || (cnt == CNT_W'(1));

    for (int i = 0; i < STAGES; i++) begin
      if (!stall[i]) begin
        valid_nxt[i] = valid_prev[i];
      end else if (!stall[i + 1]) begin
        valid_nxt[i] = 1'b0;
      end
    end

    // Flush kills the timer and the younger stages; older stages retire normally.
    if (flush) begin
      cnt_nxt                  = '0;
      done_nxt                 = 1'b0;
      valid_nxt[EXC_STAGE:0]   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      cnt     <= cnt_nxt;
      done_q  <= done_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.new_pc      = rst ? 32'd0 : bus.flush_pc;
  assign bus.stage_valid = valid_q;
  assign bus.mc_busy     = busy;
  assign bus.mc_done     = done_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a cycle-indexed behavioural model.
module tb_pipe_ctrl;
  localparam int unsigned STAGES    = 5;
  localparam int unsigned EX_STAGE  = 2;
  localparam int unsigned EXC_STAGE = 3;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned SW        = STAGES + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .STAGES(STAGES), .EX_STAGE(EX_STAGE), .EXC_STAGE(EXC_STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cycle counter, op start/end cycles, expected done cycle, valid bits.
  int              cyc        = 0;
  bit              known      = 1'b0;
  int              m_start    = -1;
  int              m_busy_end = 0;
  int              m_done_at  = -1;
  bit [STAGES-1:0] m_valid    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic [STAGES-1:0] sr, input bit st, input int len,
                      input bit fr, input logic [31:0] fpc, input bit r);
    bit              busy, done, acc, hold;
    int              req, k;
    logic [SW-1:0]   es;
    bit [SW-1:0]     vp;
    bit [STAGES-1:0] nv;

    @(negedge clk);
    rst           = r;
    bus.stallreq  = sr;
    bus.mc_start  = st;
    bus.mc_len    = CNT_W'(len);
    bus.flush_req = fr;
    bus.flush_pc  = fpc;
    #1;

    busy = (cyc > m_start) && (cyc < m_busy_end);
    done = (cyc == m_done_at);
    acc  = st && !busy && (len != 0);
    hold = busy || acc;
    req  = int'(sr) | (int'(hold) << EX_STAGE);
    k    = -1;
    for (int i = 0; i < int'(STAGES); i++) if (req[i]) k = i;
    es = (r || fr || k < 0) ? '0 : SW'((1 << (k + 2)) - 1);

    chk("stall",  32'(bus.stall), 32'(es));
    chk("flush",  32'(bus.flush), (r || !fr) ? 32'd0 : 32'd1);
    chk("new_pc", bus.new_pc, r ? 32'd0 : fpc);
    if (known) begin
      chk("stage_valid", 32'(bus.stage_valid), 32'(m_valid));
      chk("mc_busy",     32'(bus.mc_busy),     32'(busy));
      chk("mc_done",     32'(bus.mc_done),     32'(done));
    end

    if (r) begin
      m_valid    = '0;
      m_start    = -1;
      m_busy_end = 0;
      m_done_at  = -1;
      known      = 1'b1;
    end else begin
      vp = {m_valid, 1'b1};
      nv = m_valid;
      for (int i = 0; i < int'(STAGES); i++) begin
        if (!es[i])          nv[i] = vp[i];
        else if (!es[i + 1]) nv[i] = 1'b0;
      end
      if (fr) begin
        for (int i = 0; i <= int'(EXC_STAGE); i++) nv[i] = 1'b0;
        m_busy_end = 0;
        m_done_at  = -1;
      end else if (acc) begin
        m_start    = cyc;
        m_busy_end = cyc + len;
        m_done_at  = cyc + len;
      end
      m_valid = nv;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    bus.stallreq  = '0;
    bus.mc_start  = 1'b0;
    bus.mc_len    = '0;
    bus.flush_req = 1'b0;
    bus.flush_pc  = '0;

    // Reset, then pipeline fills
    step('0, 1'b0, 0, 1'b0, 32'd0, 1'b1);
    step('0, 1'b0, 0, 1'b0, 32'd0, 1'b1);
    idle(6);

    // ID load-use stall
    step(5'b00010, 1'b0, 0, 1'b0, 32'd0, 1'b0);
    idle(3);

    // Multi-cycle L=4 with overlapping ID request at t+1
    step('0, 1'b1, 4, 1'b0, 32'd0, 1'b0);
    step(5'b00010, 1'b0, 0, 1'b0, 32'd0, 1'b0);
    idle(5);

    // Flush at t+2 of an L=6 op
    step('0, 1'b1, 6, 1'b0, 32'd0, 1'b0);
    idle(1);
    step('0, 1'b0, 0, 1'b1, 32'hBFC00380, 1'b0);
    idle(8);

    // Reset at t+1 of an L=5 op
    step('0, 1'b1, 5, 1'b0, 32'd0, 1'b0);
    step('0, 1'b0, 0, 1'b0, 32'd0, 1'b1);
    idle(8);

    // Boundary lengths, ignored start while busy, flush beats start
    step('0, 1'b1, 1, 1'b0, 32'd0, 1'b0);
    idle(2);
    step('0, 1'b1, 0, 1'b0, 32'd0, 1'b0);
    idle(2);
    step('0, 1'b1, 3, 1'b0, 32'd0, 1'b0);
    step('0, 1'b1, 9, 1'b0, 32'd0, 1'b0);
    idle(4);
    step(5'b10000, 1'b1, 3, 1'b1, 32'h8000_0180, 1'b0);
    idle(4);
    step(5'b10000, 1'b0, 0, 1'b0, 32'd0, 1'b0);
    idle(2);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      logic [STAGES-1:0] sr;
      sr = ($urandom_range(0, 5) == 0) ? STAGES'($urandom) : '0;
      step(sr, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 9)),
           ($urandom_range(0, 24) == 0), $urandom, ($urandom_range(0, 120) == 0));
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the mycpu core. It generalises the fixed five-stage stall controller to `STAGES` stages and turns each stage's stall request into the core's `stall` bus. It also adds three things the old controller lacked:
- a multi-cycle operation timer for mult/div, which holds the EX stage;
- exception/eret flush with PC redirect;
- per-stage instruction-valid tracking.

It sits beside the stage modules and drives their `stall` inputs.

## Interface
Parameters:
- `STAGES`, 5: number of pipeline stages, indexed 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
- `EX_STAGE`, 2: stage held by the multi-cycle timer.
- `EXC_STAGE`, 3: deepest stage cleared on flush.
- `CNT_W`, 6: width of the multi-cycle length.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous active-high reset.
- `stallreq`  in  STAGES  bit k is the stall request from stage k.
- `mc_start`  in  1  multi-cycle operation begins in EX this cycle.
- `mc_len`  in  CNT_W  operation length L in cycles, sampled with `mc_start`.
- `flush_req`  in  1  exception/eret detected at `EXC_STAGE`.
- `flush_pc`  in  32  redirect target.
- `stall`  out  STAGES+1  bit i holds stage i's input register; bit 0 is the PC.
- `flush`  out  1  clears stages 0..EXC_STAGE this cycle.
- `new_pc`  out  32  redirect PC, valid while `flush`=1.
- `stage_valid`  out  STAGES  bit i=1 when stage i holds a real instruction.
- `mc_busy`  out  1  timer running.
- `mc_done`  out  1  one-cycle pulse: multi-cycle result ready.

## Operation
- Effective request vector: `req = stallreq | (mc_hold << EX_STAGE)`.
  - `mc_hold = mc_busy | (mc_start & !mc_busy & mc_len!=0)`.
- Let k be the highest set bit of `req`. Then `stall[k+1:0]` are all 1 and the rest are 0. If `req==0`, then `stall=0`.
- Stage k+1 receives a bubble: its stall bit is 0 and stage k's is 1.
- Timer:
  - On an accepted `mc_start` with L≥1, `cnt <= L-1`.
  - `mc_busy = (cnt != 0)`.
  - `mc_done` is a registered pulse, set the cycle after `cnt` goes 1→0, or the cycle after an accepted start with L=1.
  - `mc_start` while `mc_busy` is ignored.
  - L=0 produces no stall and no `mc_done`.
- Flush:
  - `flush = flush_req` (combinational), and `new_pc = flush_pc`.
  - While `flush`=1, `stall` is forced to 0. Flush beats every stall request.
  - At the edge, `stage_valid[EXC_STAGE:0] <= 0`, `cnt <= 0`, and `mc_done` is suppressed.
  - Stages above `EXC_STAGE` advance normally.
- Valid tracking per edge, with `stall[STAGES]` treated as defined and `valid[-1]=1`:
  - If `stall[i]=0`: `valid[i] <= valid[i-1]`.
  - If `stall[i]=1` and `stall[i+1]=0`: `valid[i] <= 0` (bubble).
  - If both are 1: hold.

## Timing
- `stall`, `flush` and `new_pc` are combinational; they are seen by the stages in the same cycle as the request.
- `stage_valid`, `cnt`/`mc_busy` and `mc_done` are registered.
- Multi-cycle start in cycle t with length L:
  - EX stall asserted for cycles t..t+L-1.
  - `mc_done`=1 and stall released in cycle t+L.
  - The instruction leaves EX at the end of t+L.
- Reset:
  - While `rst`=1: `stall=0`, `flush=0`, `new_pc=0`.
  - After the reset edge: `stage_valid=0`, `cnt=0`, `mc_busy=0`, `mc_done=0`.
  - Valid bits then fill one stage per cycle (stage 0 first).
- Reset asserted mid-operation aborts the timer; no `mc_done` is issued.
- `flush_req` and `mc_start` in the same cycle: the flush wins and the timer is not loaded.

## Test plan
- Reset, then 6 free-running cycles:
  - `stall=6'b000000` throughout.
  - `stage_valid` goes 00001, 00011, … 11111 by the fifth post-reset edge.
- `stallreq=5'b00010` (ID load-use) for 1 cycle:
  - `stall=6'b000111` that cycle.
  - `stage_valid[2]=0` next cycle; `stage_valid[1:0]` held.
- `mc_start` with `mc_len=4` at cycle t:
  - `stall=6'b001111` for cycles t..t+3.
  - `mc_busy` high for t+1..t+3.
  - `mc_done=1` at t+4 only.
- `mc_len=4` in progress, plus `stallreq[1]` at t+1: `stall` stays `6'b001111` (highest request wins).
- Flush during the multi-cycle op:
  - Setup: `mc_len=6`, `flush_req=1`, `flush_pc=32'hBFC00380` at t+2.
  - That cycle: `stall=0`, `flush=1`, `new_pc=32'hBFC00380`.
  - Next cycle: `stage_valid[3:0]=0`, `mc_busy=0`, and `mc_done` is never asserted.
- `rst` asserted at t+1 of an `mc_len=5` op: all outputs reset next cycle, and no `mc_done` follows.
